ghost_motion: RTL and testbench
===============================

GHOST_MOTION -- requirements
Module: ghost_motion

Interface
REQ-001 SHALL have parameter START_X, default 11'd320, meaning ghost x after reset.
REQ-002 SHALL have parameter START_Y, default 10'd240, meaning ghost y after reset.
REQ-003 SHALL have parameter TILE, default 16, meaning pixels per tile (power of two, 2..64).
REQ-004 SHALL have parameter X_MIN, default 11'd0, meaning leftmost legal x.
REQ-005 SHALL have parameter X_MAX, default 11'd624, meaning rightmost legal x.
REQ-006 SHALL have parameter CATCH_DIST, default 8, meaning catch radius in pixels per axis.
REQ-007 SHALL have port clk, input, 1, meaning the single clock.
REQ-008 SHALL have port rst, input, 1, meaning reset, synchronous, active-low.
REQ-009 SHALL have port move_tick, input, 1, meaning one-cycle step strobe.
REQ-010 SHALL have port freeze, input, 1, meaning game pause.
REQ-011 SHALL have port move_direction, input, 4, meaning one-hot request (RIGHT 0001, UP 0010, DOWN 0100, LEFT 1000).
REQ-012 SHALL have port valid_moves, input, 4, meaning legal directions at the current position.
REQ-013 SHALL have port pacman_pos_x, input, 11, meaning pacman x.
REQ-014 SHALL have port pacman_pos_y, input, 10, meaning pacman y.
REQ-015 SHALL have port ghost_pos_x, output, 11, meaning registered ghost x.
REQ-016 SHALL have port ghost_pos_y, output, 10, meaning registered ghost y.
REQ-017 SHALL have port prev_direction, output, 4, meaning the latched direction, fed back to the ghost controller.
REQ-018 SHALL have port tile_arrive, output, 1, meaning a one-cycle pulse when the ghost lands on a tile boundary.
REQ-019 SHALL have port caught, output, 1, meaning sticky pacman-caught flag.

Function
REQ-020 SHALL implement three states: IDLE, MOVE and CAUGHT.
REQ-021 SHALL move IDLE->MOVE on the first move_tick with freeze=0, and perform that tick's step in the same cycle.
REQ-022 SHALL act only on move_tick=1 and freeze=0; all other cycles hold position, step_cnt and prev_direction.
REQ-023 SHALL, on a qualifying tick with step_cnt==0 where move_direction is one-hot and (move_direction & valid_moves)!=0, latch move_direction into prev_direction.
REQ-024 SHALL otherwise, at step_cnt==0, keep prev_direction if (prev_direction & valid_moves)!=0, else clear it to 0000 and not move.
REQ-025 SHALL ignore move_direction and valid_moves while step_cnt!=0, continuing in prev_direction.
REQ-026 SHALL, on each qualifying tick with prev_direction!=0 (after latching), move the position by exactly 1 pixel (RIGHT x+1, LEFT x-1, DOWN y+1, UP y-1) and set step_cnt=(step_cnt+1) mod TILE.
REQ-027 SHALL update position and step_cnt registers one clk after the tick cycle.
REQ-028 SHALL pulse tile_arrive for one cycle, concurrently with the position update, when step_cnt becomes 0.
REQ-029 SHALL compute the catch condition each cycle in MOVE as |ghost_pos_x-pacman_pos_x|<CATCH_DIST and |ghost_pos_y-pacman_pos_y|<CATCH_DIST, using unsigned-safe subtraction (larger minus smaller).
REQ-030 SHALL, on the catch condition, enter CAUGHT and set caught=1 next cycle; a coincident tick is discarded.
REQ-031 SHALL, in CAUGHT, hold all outputs, with tile_arrive=0 and caught=1, until reset.
REQ-032 SHALL, when a move would leave [X_MIN,X_MAX], behave per REQ-037/REQ-038.

Reset
REQ-033 SHALL, on rst=0 at a clk edge, set the state to IDLE, ghost_pos_x=START_X, ghost_pos_y=START_Y, prev_direction=0000, step_cnt=0, tile_arrive=0 and caught=0.
REQ-034 SHALL give reset priority over move_tick, freeze and catch, including mid-tile.
REQ-035 SHALL produce reset values from the first edge with rst=0, with no reset dependence on inputs.

Configuration
REQ-036 SHALL use the macro GHOST_TUNNEL_WRAP_EN.
REQ-037 SHALL, with GHOST_TUNNEL_WRAP_EN defined, move LEFT at X_MIN to X_MAX and RIGHT at X_MAX to X_MIN, advancing step_cnt normally.
REQ-038 SHALL, without GHOST_TUNNEL_WRAP_EN, hold x at the bound, leave step_cnt unchanged and clear prev_direction to 0000.

Verification
REQ-039 SHALL verify: reset, then a tick with move_direction=0001 and valid_moves=1111 -> next cycle x=321, prev_direction=0001, state MOVE.
REQ-040 SHALL verify: 16 ticks RIGHT, with move_direction switched to 0100 after tick 3 -> x=336 and y=240, tile_arrive pulses once after tick 16, and the 17th tick moves DOWN (y=241).
REQ-041 SHALL verify: at a tile boundary, request 0010 with valid_moves=0001 and prev_direction=0001 -> RIGHT continues; with valid_moves=0000 -> prev_direction=0000 and no move.
REQ-042 SHALL verify: pacman at (325,244), ghost stepping from (320,240) -> caught=1 one cycle after the condition, and further ticks leave the position frozen.
REQ-043 SHALL verify: ghost at X_MAX=624 with RIGHT -> x=0 when GHOST_TUNNEL_WRAP_EN is defined; x=624 and prev_direction=0000 when it is not.
REQ-044 SHALL verify: rst=0 asserted mid-tile (step_cnt=7) with a coincident move_tick and freeze=1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ghost_motion.sv
// Ghost motion engine: steps one pixel per move tick along a tile grid.
// Optional macro GHOST_TUNNEL_WRAP_EN wraps x between X_MIN and X_MAX.
module ghost_motion #(
    parameter logic [10:0] START_X    = 11'd320,
    parameter logic [9:0]  START_Y    = 10'd240,
    parameter int          TILE       = 16,
    parameter logic [10:0] X_MIN      = 11'd0,
    parameter logic [10:0] X_MAX      = 11'd624,
    parameter int          CATCH_DIST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_tick,
    input  logic        freeze,
    input  logic [3:0]  move_direction,
    input  logic [3:0]  valid_moves,
    input  logic [10:0] pacman_pos_x,
    input  logic [9:0]  pacman_pos_y,
    output logic [10:0] ghost_pos_x,
    output logic [9:0]  ghost_pos_y,
    output logic [3:0]  prev_direction,
    output logic        tile_arrive,
    output logic        caught
);

    localparam int SW = (TILE > 2) ? $clog2(TILE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MOVE   = 2'd1;
    localparam logic [1:0] S_CAUGHT = 2'd2;

    localparam logic [3:0] DIR_R = 4'b0001;
    localparam logic [3:0] DIR_U = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0100;
    localparam logic [3:0] DIR_L = 4'b1000;

    localparam logic [10:0] CDX = 11'(CATCH_DIST);
    localparam logic [9:0]  CDY = 10'(CATCH_DIST);

    logic [1:0]    state_q, state_d;
    logic [10:0]   x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [3:0]    dir_q, dir_d;
    logic [SW-1:0] step_q, step_d;
    logic          tile_q, tile_d;
    logic          caught_q, caught_d;

    logic [3:0]    dir_sel;
    logic [SW-1:0] step_inc;
    logic [10:0]   dx;
    logic [9:0]    dy;
    logic          catch_hit;
    logic          qual;
    logic          adv;

    assign qual     = move_tick & ~freeze;
    assign step_inc = step_q + 1'b1;

    // Distance to pacman per axis, always larger minus smaller.
    always_comb begin
        dx = (x_q >= pacman_pos_x) ? (x_q - pacman_pos_x)
                                   : (pacman_pos_x - x_q);
        dy = (y_q >= pacman_pos_y) ? (y_q - pacman_pos_y)
                                   : (pacman_pos_y - y_q);
        catch_hit = (dx < CDX) && (dy < CDY);
    end

    // Direction for this tick: new requests only count on a tile boundary.
    always_comb begin
        dir_sel = dir_q;
        if (step_q == '0) begin
            if ($onehot(move_direction) &&
                ((move_direction & valid_moves) != 4'b0000)) begin
                dir_sel = move_direction;
            end else if ((dir_q & valid_moves) != 4'b0000) begin
                dir_sel = dir_q;
            end else begin
                dir_sel = 4'b0000;
            end
        end
    end

    // Next-state: catch check first, then one pixel step on a live tick.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        step_d   = step_q;
        tile_d   = 1'b0;
        caught_d = caught_q;
        adv      = 1'b0;
        case (state_q)
            S_CAUGHT: begin
                caught_d = 1'b1;
            end
            S_IDLE, S_MOVE: begin
                if ((state_q == S_MOVE) && catch_hit) begin
                    state_d  = S_CAUGHT;
                    caught_d = 1'b1;
                end else if (qual) begin
                    state_d = S_MOVE;
                    dir_d   = dir_sel;
                    case (dir_sel)
                        DIR_R: begin
                            if (x_q >= X_MAX) begin
`ifdef GHOST_TUNNEL_WRAP_EN
                                x_d = X_MIN;
                                adv = 1'b1;
`else
                                dir_d = 4'b0000;
`endif
                            end else begin
                                x_d = x_q + 11'd1;
                                adv = 1'b1;
                            end
                        end
                        DIR_L: begin
                            if (x_q <= X_MIN) begin
`ifdef GHOST_TUNNEL_WRAP_EN
                                x_d = X_MAX;
                                adv = 1'b1;
`else
                                dir_d = 4'b0000;
`endif
                            end else begin
                                x_d = x_q - 11'd1;
                                adv = 1'b1;
                            end
                        end
                        DIR_D: begin
                            y_d = y_q + 10'd1;
                            adv = 1'b1;
                        end
                        DIR_U: begin
                            y_d = y_q - 10'd1;
                            adv = 1'b1;
                        end
                        default: begin
                            adv = 1'b0;
                        end
                    endcase
                    if (adv) begin
                        step_d = step_inc;
                        tile_d = (step_inc == '0);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            x_q      <= START_X;
            y_q      <= START_Y;
            dir_q    <= 4'b0000;
            step_q   <= '0;
            tile_q   <= 1'b0;
            caught_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            tile_q   <= tile_d;
            caught_q <= caught_d;
        end
    end

    assign ghost_pos_x    = x_q;
    assign ghost_pos_y    = y_q;
    assign prev_direction = dir_q;
    assign tile_arrive    = tile_q;
    assign caught         = caught_q;

endmodule

// File: tb/tb_ghost_motion.sv
// Scoreboard bench for ghost_motion: driver feeds a behavioural model,
// monitor compares every registered output cycle against it.
module tb_ghost_motion;

    localparam int SX = 320;
    localparam int SY = 240;
    localparam int XMAX = 624;
    localparam int XMIN = 0;
    localparam int TL = 16;
    localparam int CD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        move_tick = 1'b0;
    logic        freeze = 1'b0;
    logic [3:0]  move_direction = 4'b0;
    logic [3:0]  valid_moves = 4'b0;
    logic [10:0] pacman_pos_x = 11'd0;
    logic [9:0]  pacman_pos_y = 10'd0;
    logic [10:0] ghost_pos_x;
    logic [9:0]  ghost_pos_y;
    logic [3:0]  prev_direction;
    logic        tile_arrive;
    logic        caught;

    ghost_motion dut (
        .clk(clk),
        .rst(rst),
        .move_tick(move_tick),
        .freeze(freeze),
        .move_direction(move_direction),
        .valid_moves(valid_moves),
        .pacman_pos_x(pacman_pos_x),
        .pacman_pos_y(pacman_pos_y),
        .ghost_pos_x(ghost_pos_x),
        .ghost_pos_y(ghost_pos_y),
        .prev_direction(prev_direction),
        .tile_arrive(tile_arrive),
        .caught(caught)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [3:0] d;
        logic       ta;
        logic       c;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;

    int         mx = SX;
    int         my = SY;
    logic [3:0] mdir = 4'b0;
    int         msteps = 0;
    bit         started = 0;
    bit         mcaught = 0;
    bit         mta = 0;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference rules applied to the inputs currently on the pins.
    task automatic model_step();
        logic [3:0] nd;
        bit moved;
        mta = 0;
        if (!rst) begin
            mx = SX; my = SY; mdir = 4'b0; msteps = 0;
            started = 0; mcaught = 0;
            return;
        end
        if (mcaught) return;
        if (started && absd(mx, int'(pacman_pos_x)) < CD &&
            absd(my, int'(pacman_pos_y)) < CD) begin
            mcaught = 1;
            return;
        end
        if (!(move_tick && !freeze)) return;
        started = 1;
        if (msteps == 0) begin
            if ($countones(move_direction) == 1 &&
                (move_direction & valid_moves) != 4'b0)
                nd = move_direction;
            else if ((mdir & valid_moves) != 4'b0)
                nd = mdir;
            else
                nd = 4'b0;
        end else begin
            nd = mdir;
        end
        mdir = nd;
        moved = 0;
        if (nd == 4'b0001) begin
            if (mx >= XMAX) begin
`ifdef GHOST_TUNNEL_WRAP_EN
                mx = XMIN; moved = 1;
`else
                mdir = 4'b0;
`endif
            end else begin
                mx = mx + 1; moved = 1;
            end
        end else if (nd == 4'b1000) begin
            if (mx <= XMIN) begin
`ifdef GHOST_TUNNEL_WRAP_EN
                mx = XMAX; moved = 1;
`else
                mdir = 4'b0;
`endif
            end else begin
                mx = mx - 1; moved = 1;
            end
        end else if (nd == 4'b0100) begin
            my = (my + 1) % 1024; moved = 1;
        end else if (nd == 4'b0010) begin
            my = (my + 1023) % 1024; moved = 1;
        end
        if (moved) begin
            msteps = (msteps + 1) % TL;
            mta = (msteps == 0);
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit f,
                       input logic [3:0] d, input logic [3:0] v,
                       input logic [10:0] px, input logic [9:0] py);
        exp_t e;
        @(negedge clk);
        rst = r;
        move_tick = t;
        freeze = f;
        move_direction = d;
        valid_moves = v;
        pacman_pos_x = px;
        pacman_pos_y = py;
        model_step();
        e.x = mx; e.y = my; e.d = mdir; e.ta = mta; e.c = mcaught;
        q.push_back(e);
    endtask

    task automatic tk(input logic [3:0] d, input logic [3:0] v);
        cyc(1, 1, 0, d, v, 11'd0, 10'd0);
    endtask

    task automatic idle();
        cyc(1, 0, 0, 4'b0, 4'b0, 11'd0, 10'd0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 4'b0, 4'b0, 11'd0, 10'd0);
    endtask

    // Monitor: pop one expectation per clock edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (int'(ghost_pos_x) == e.x && int'(ghost_pos_y) == e.y &&
                    prev_direction === e.d && tile_arrive === e.ta &&
                    caught === e.c) begin
                    passes++;
                end else begin
                    $display("FAIL outputs t=%0t got x=%0d y=%0d d=%b ta=%b c=%b want x=%0d y=%0d d=%b ta=%b c=%b",
                             $time, ghost_pos_x, ghost_pos_y, prev_direction,
                             tile_arrive, caught, e.x, e.y, e.d, e.ta, e.c);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [3:0] d;
        logic [3:0] v;
        logic [10:0] px;
        logic [9:0] py;
        // first tick after reset
        do_reset();
        idle();
        tk(4'b0001, 4'b1111);
        idle();
        // a full tile right, request DOWN mid-tile, then DOWN at boundary
        for (int i = 2; i <= 16; i++) begin
            tk((i > 3) ? 4'b0100 : 4'b0001, 4'b1111);
            cyc(1, 1, 1, 4'b1000, 4'b0000, 11'd0, 10'd0);
        end
        tk(4'b0100, 4'b1111);
        idle();
        // invalid request at boundary, then dead end
        do_reset();
        for (int i = 0; i < 16; i++) tk(4'b0001, 4'b1111);
        tk(4'b0010, 4'b0001);
        for (int i = 0; i < 15; i++) tk(4'b0001, 4'b1111);
        tk(4'b0010, 4'b0000);
        tk(4'b0000, 4'b0000);
        // catch
        do_reset();
        cyc(1, 1, 0, 4'b0001, 4'b1111, 11'd325, 10'd244);
        for (int i = 0; i < 5; i++)
            cyc(1, 1, 0, 4'b0001, 4'b1111, 11'd325, 10'd244);
        // right edge
        do_reset();
        for (int i = 0; i < 310; i++) tk(4'b0001, 4'b1111);
        // left edge
        do_reset();
        for (int i = 0; i < 330; i++) tk(4'b1000, 4'b1111);
        // reset mid-tile with tick and freeze
        do_reset();
        for (int i = 0; i < 7; i++) tk(4'b0001, 4'b1111);
        cyc(0, 1, 1, 4'b0001, 4'b1111, 11'd0, 10'd0);
        idle();
        // randomized episodes
        for (int ep = 0; ep < 20; ep++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 9) < 7)
                    d = 4'b0001 << $urandom_range(0, 3);
                else
                    d = 4'($urandom);
                v = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
                if ($urandom_range(0, 19) == 0) begin
                    px = 11'(mx + $urandom_range(0, 20) - 10);
                    py = 10'(my + $urandom_range(0, 20) - 10);
                end else begin
                    px = 11'(mx + 300);
                    py = 10'(my + 200);
                end
                cyc($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) == 0, d, v, px, py);
            end
        end
        idle();
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain left=%0d want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
